hex_display_ctrl: RTL and testbench

Avalon-MM slave controller that sequences the HEX3..HEX0 seven-segment bus (out_port, 8 bits per digit, active-high segments, bit7 = DP). It selects between CPU raw segment patterns and a hardware 16-bit value stream, such as MLP result or status. The hardware stream is accepted with a valid/ready handshake, decoded to hex glyphs and rate-limited by a programmable hold timer so each value stays readable. It replaces the plain PIO in the QSYS system; the top level applies board polarity inversion.

---
 rtl/hex_display_pkg.sv | 27 ++
 rtl/hex_display_ctrl_glyph.sv | 16 +
 rtl/hex_display_ctrl.sv | 155 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared definitions for the HEX3..HEX0 display controller.
//   - Avalon register addresses (CTRL, RAW, LAST, HOLD)
//   - CTRL register bit indices
//   - hold state machine encoding
//   - hex glyph table (active-high segments, bit7 = DP, DP always 0 here)
package hex_display_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_LAST = 2'd2;
    localparam logic [1:0] ADDR_HOLD = 2'd3;

    localparam int CTRL_MODE_BIT = 0;  // 0 = RAW pattern, 1 = HW value
    localparam int CTRL_LZB_BIT  = 1;  // blank leading zero digits in HW mode

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

    // Entry n is the glyph for nibble n; entry 0 is the least significant byte.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,  // F..8
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F   // 7..0
    };

endpackage

// File: rtl/hex_display_ctrl_glyph.sv
// hex_glyph_decode: combinational nibble -> seven-segment glyph.
// Ports:
//   nibble   in  4  hex digit to show
//   blank    in  1  force all segments off
//   segments out 8  active-high segments, bit7 = DP (always 0)
module hex_glyph_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] segments
);

    assign segments = blank ? 8'h00 : GLYPH_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM slave driving the HEX3..HEX0 segment bus.
// Shows either a CPU-written raw segment pattern or a 16-bit hardware value
// decoded to hex glyphs. Hardware values arrive via valid/ready and are
// rate-limited by a programmable hold timer so each one stays readable.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address[1:0]          register select (CTRL, RAW, LAST, HOLD)
//   chipselect, write_n   write when chipselect && !write_n
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read data, zero wait states
//   hw_value[15:0]        hardware value to display
//   hw_valid / hw_ready   handshake: a value transfers on a clock edge where
//                         both are high; hw_value must be stable while valid.
//   out_port[31:0]        registered segment bus {HEX3,HEX2,HEX1,HEX0}
//
// Build option: define HEX_CTRL_HOLD_DP_EN to light HEX0 DP (out_port[7])
// in HW mode while a hold is running.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int          HOLD_W    = 32,
    parameter logic [31:0] RAW_RESET = 32'h0000_3F06
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] hw_value,
    input  logic        hw_valid,
    output logic        hw_ready,
    output logic [31:0] out_port
);

    localparam logic [HOLD_W-1:0] ONE = HOLD_W'(1);

    logic [1:0]        ctrl_q,  ctrl_d;
    logic [31:0]       raw_q,   raw_d;
    logic [15:0]       last_q,  last_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [HOLD_W-1:0] cnt_q,   cnt_d;
    hold_state_t       state_q, state_d;
    logic [31:0]       out_d;
    logic [3:0]        blank;
    logic [31:0]       seg_word;
    logic              wr_en;
    logic              accept;

    assign wr_en  = chipselect && !write_n;
    // hw_ready is a flop that mirrors the state, so accept implies IDLE.
    assign accept = hw_ready && hw_valid;

    // Register file next values.
    always_comb begin
        ctrl_d = ctrl_q;
        raw_d  = raw_q;
        hold_d = hold_q;
        last_d = last_q;
        if (wr_en) begin
            case (address)
                ADDR_CTRL: ctrl_d = writedata[1:0];
                ADDR_RAW:  raw_d  = writedata;
                ADDR_HOLD: hold_d = writedata[HOLD_W-1:0];
                default:   ;  // LAST is read-only
            endcase
        end
        if (accept) begin
            last_d = hw_value;
        end
    end

    // Hold state machine: the count is loaded only at accept, so HOLD
    // writes during a running hold apply to the next one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && (hold_q > ONE)) begin
                    cnt_d   = hold_q - ONE;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Leading-zero blanking cascades from HEX3 down; HEX0 is never blanked.
    always_comb begin
        blank[3] = ctrl_d[CTRL_LZB_BIT] && (last_d[15:12] == 4'h0);
        blank[2] = blank[3] && (last_d[11:8] == 4'h0);
        blank[1] = blank[2] && (last_d[7:4] == 4'h0);
        blank[0] = 1'b0;
    end

    for (genvar g = 0; g < 4; g++) begin : g_digit
        hex_glyph_decode u_dec (
            .nibble   (last_d[g*4 +: 4]),
            .blank    (blank[g]),
            .segments (seg_word[g*8 +: 8])
        );
    end

    // Output is built from next-cycle register values so a CTRL write and
    // an accept in the same cycle both show up together.
    always_comb begin
        out_d = ctrl_d[CTRL_MODE_BIT] ? seg_word : raw_d;
`ifdef HEX_CTRL_HOLD_DP_EN
        if (ctrl_d[CTRL_MODE_BIT] && (state_d == HOLD)) begin
            out_d[7] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= 2'b00;
            raw_q    <= RAW_RESET;
            last_q   <= 16'h0000;
            hold_q   <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            hw_ready <= 1'b0;
            out_port <= RAW_RESET;
        end else begin
            ctrl_q   <= ctrl_d;
            raw_q    <= raw_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hw_ready <= (state_d == IDLE);
            out_port <= out_d;
        end
    end

    always_comb begin
        case (address)
            ADDR_CTRL: readdata = {30'b0, ctrl_q};
            ADDR_RAW:  readdata = raw_q;
            ADDR_LAST: readdata = {16'b0, last_q};
            default:   readdata = 32'(hold_q);
        endcase
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed testbench for hex_display_ctrl.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] hw_value;
    logic        hw_valid;
    logic        hw_ready;
    logic [31:0] out_port;

    int n_checks = 0;
    int n_bad    = 0;

`ifdef HEX_CTRL_HOLD_DP_EN
    localparam logic [31:0] DP_HOLD = 32'h0000_0080;
`else
    localparam logic [31:0] DP_HOLD = 32'h0000_0000;
`endif

    hex_display_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hw_value   (hw_value),
        .hw_valid   (hw_valid),
        .hw_ready   (hw_ready),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic send_hw(input logic [15:0] v);
        hw_value = v;
        hw_valid = 1'b1;
        step();
        hw_valid = 1'b0;
    endtask

    logic [31:0] exp_glyph [1:3];
    int          low_cnt;

    initial begin
        exp_glyph[1] = 32'h0000_0006;
        exp_glyph[2] = 32'h0000_005B;
        exp_glyph[3] = 32'h0000_004F;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        hw_value   = 16'h0;
        hw_valid   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out_port, 32'h0000_3F06);
        check("rst_ready", {31'b0, hw_ready}, 32'h0);
        reset_n = 1'b1;
        check_reg("rst_ctrl", 2'd0, 32'h0);
        check_reg("rst_raw", 2'd1, 32'h0000_3F06);
        check_reg("rst_last", 2'd2, 32'h0);
        check_reg("rst_hold", 2'd3, 32'h0);
        step();
        check("ready_after_rst", {31'b0, hw_ready}, 32'h1);

        // RAW mode
        cpu_write(2'd1, 32'h7177_7C39);
        check("raw_out", out_port, 32'h7177_7C39);
        send_hw(16'h1234);
        check("raw_out_keep", out_port, 32'h7177_7C39);
        check_reg("raw_last", 2'd2, 32'h0000_1234);

        // HW decode
        cpu_write(2'd0, 32'h1);
        check("mode_switch", out_port, 32'h065B_4F66);
        send_hw(16'hBEEF);
        check("hw_beef", out_port, 32'h7C79_7971);
        cpu_write(2'd0, 32'h3);
        check("lzb_beef", out_port, 32'h7C79_7971);
        send_hw(16'h0007);
        check("lzb_0007", out_port, 32'h0000_0007);
        send_hw(16'h0000);
        check("lzb_0000", out_port, 32'h0000_003F);
        cpu_write(2'd2, 32'hFFFF_FFFF);
        check_reg("last_ro", 2'd2, 32'h0);
        cpu_write(2'd0, 32'hFFFF_FFFF);
        check_reg("ctrl_upper", 2'd0, 32'h3);

        // Hold timing: HOLD=5, valid held high with 1,2,3
        cpu_write(2'd3, 32'd5);
        check_reg("hold_rd", 2'd3, 32'd5);
        hw_valid = 1'b1;
        hw_value = 16'd1;
        for (int v = 1; v <= 3; v++) begin
            step();  // accept edge for v
            check_reg($sformatf("hold_last_%0d", v), 2'd2, 32'(v));
            if (v < 3) begin
                hw_value = 16'(v + 1);
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("hold_rdy_%0d_%0d", v, i), {31'b0, hw_ready}, 32'h0);
                    check($sformatf("hold_out_%0d_%0d", v, i), out_port, exp_glyph[v] | DP_HOLD);
                    check_reg($sformatf("hold_keep_%0d_%0d", v, i), 2'd2, 32'(v));
                    step();
                end
                check($sformatf("hold_end_rdy_%0d", v), {31'b0, hw_ready}, 32'h1);
                check($sformatf("hold_end_out_%0d", v), out_port, exp_glyph[v]);
            end
        end
        hw_valid = 1'b0;

        // Mid-hold HOLD write: current hold still 5, next hold 100
        cpu_write(2'd3, 32'd100);
        check("mid_rdy1", {31'b0, hw_ready}, 32'h0);
        step();
        check("mid_rdy2", {31'b0, hw_ready}, 32'h0);
        step();
        check("mid_rdy3", {31'b0, hw_ready}, 32'h0);
        step();
        check("mid_rdy_end", {31'b0, hw_ready}, 32'h1);
        send_hw(16'd4);
        low_cnt = 0;
        for (int i = 0; i < 200 && !hw_ready; i++) begin
            low_cnt++;
            step();
        end
        check("hold100_len", 32'(low_cnt), 32'd99);

        // Reset asserted mid-hold
        cpu_write(2'd3, 32'd5);
        send_hw(16'd5);
        step();
        step();
        check("pre_rst_rdy", {31'b0, hw_ready}, 32'h0);
        reset_n = 1'b0;
        #2;
        check("midrst_out", out_port, 32'h0000_3F06);
        check("midrst_rdy", {31'b0, hw_ready}, 32'h0);
        check_reg("midrst_ctrl", 2'd0, 32'h0);
        check_reg("midrst_last", 2'd2, 32'h0);
        check_reg("midrst_hold", 2'd3, 32'h0);
        reset_n = 1'b1;
        step();
        check("postrst_rdy", {31'b0, hw_ready}, 32'h1);
        check("postrst_out", out_port, 32'h0000_3F06);
        send_hw(16'd6);
        check_reg("postrst_last", 2'd2, 32'h0000_0006);
        check("postrst_rdy2", {31'b0, hw_ready}, 32'h1);

        // Collision: CTRL write MODE=1 with accept of A5A5
        hw_value = 16'hA5A5;
        hw_valid = 1'b1;
        cpu_write(2'd0, 32'h1);
        hw_valid = 1'b0;
        check("collide_out", out_port, 32'h776D_776D);
        check_reg("collide_last", 2'd2, 32'h0000_A5A5);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
